// File: rtl/hub75e_pkg.sv
// Shared defaults and the receiver state type for the HUB75E capture path.
package hub75e_pkg;

    localparam int COLS_DEF  = 64;
    localparam int ROW_W_DEF = 4;
    localparam int PIX_W     = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } rx_state_t;

endpackage

// File: rtl/hub75e_rx_sync.sv
// Two-flop synchronizer for a bus of asynchronous pins.
// Rising-edge detection is applied to the low EDGE_W bits.
module hub75e_rx_sync #(
    parameter int W      = 8,
    parameter int EDGE_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [W-1:0]      in_i,
    output logic [W-EDGE_W-1:0] level_o,
    output logic [EDGE_W-1:0] rise_o
);

    logic [W-1:0]      meta_q;
    logic [W-1:0]      sync_q;
    logic [EDGE_W-1:0] dly_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            meta_q <= in_i;
            sync_q <= meta_q;
            dly_q  <= sync_q[EDGE_W-1:0];
        end
    end

    // Levels and edges both come from sync_q, so they stay cycle-aligned.
    assign level_o = sync_q[W-1:EDGE_W];
    assign rise_o  = sync_q[EDGE_W-1:0] & ~dly_q;

endmodule

// File: rtl/hub75e_rx.sv
// HUB75E bus receiver: reassembles each latched line and streams it,
// one column per cycle, into a {row, col} addressed capture RAM.
module hub75e_rx
    import hub75e_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int ROW_W = ROW_W_DEF,
    localparam int COL_W = $clog2(COLS),
    localparam int AW    = ROW_W + COL_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hub75e_clk_i,
    input  logic             hub75e_lat_i,
    input  logic             hub75e_r0_i,
    input  logic             hub75e_g0_i,
    input  logic             hub75e_b0_i,
    input  logic             hub75e_r1_i,
    input  logic             hub75e_g1_i,
    input  logic             hub75e_b1_i,
    input  logic [ROW_W-1:0] hub75e_addr_i,
    output logic             ram_wr_en_o,
    output logic [AW-1:0]    ram_wr_addr_o,
    output logic [2:0]       ram_wr_data_ch0_o,
    output logic [2:0]       ram_wr_data_ch1_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             len_err_o,
    output logic             ovf_err_o
);

    localparam int CNT_W = COL_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(COLS + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic [ROW_W+PIX_W-1:0] bus_s;
    logic [1:0]             rise_s;
    logic [PIX_W-1:0]       pix_s;
    logic [ROW_W-1:0]       addr_s;
    logic                   clk_rise;
    logic                   lat_rise;

    hub75e_rx_sync #(
        .W      (ROW_W + PIX_W + 2),
        .EDGE_W (2)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_i    ({hub75e_addr_i,
                   hub75e_r0_i, hub75e_g0_i, hub75e_b0_i,
                   hub75e_r1_i, hub75e_g1_i, hub75e_b1_i,
                   hub75e_lat_i, hub75e_clk_i}),
        .level_o (bus_s),
        .rise_o  (rise_s)
    );

    assign pix_s    = bus_s[PIX_W-1:0];
    assign addr_s   = bus_s[ROW_W+PIX_W-1:PIX_W];
    assign clk_rise = rise_s[0];
    assign lat_rise = rise_s[1];

    logic [COLS-1:0][PIX_W-1:0] sr_q, sr_d, hold_q;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [COL_W-1:0]           fill_col;
    rx_state_t                  state_q;
    logic [ROW_W-1:0]           row_q;
    logic [COL_W-1:0]           col_q;

    logic             wr_en_q;
    logic [AW-1:0]    wr_addr_q;
    logic [PIX_W-1:0] wr_data_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             len_err_q;
    logic             ovf_err_q;

    // The first COLS pixels of a line land directly in column COLS-1-k so a
    // short line leaves the remaining columns stale; past COLS the register
    // shifts, keeping only the most recent COLS pixels.
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        fill_col = COL_LAST - cnt_q[COL_W-1:0];
        if (clk_rise) begin
            if (cnt_q >= CNT_FULL) begin
                sr_d = {sr_q[COLS-2:0], pix_s};
            end else begin
                sr_d[fill_col] = pix_s;
            end
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            hold_q       <= '0;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
            ovf_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lat_rise) begin
                        // sr_d so a pixel clocked in this same cycle is kept.
                        hold_q    <= sr_d;
                        row_q     <= addr_s;
                        col_q     <= '0;
                        len_err_q <= (cnt_d != CNT_FULL);
                        cnt_q     <= '0;
                        state_q   <= FLUSH;
                    end
                end
                FLUSH: begin
                    wr_en_q      <= 1'b1;
                    busy_q       <= 1'b1;
                    wr_addr_q    <= {row_q, col_q};
                    wr_data_q    <= hold_q[col_q];
                    frame_done_q <= (col_q == COL_LAST) && (&row_q);
                    ovf_err_q    <= lat_rise;
                    col_q        <= col_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign ram_wr_en_o       = wr_en_q;
    assign ram_wr_addr_o     = wr_addr_q;
    assign ram_wr_data_ch0_o = wr_data_q[5:3];
    assign ram_wr_data_ch1_o = wr_data_q[2:0];
    assign busy_o            = busy_q;
    assign frame_done_o      = frame_done_q;
    assign len_err_o         = len_err_q;
    assign ovf_err_o         = ovf_err_q;

endmodule

// File: tb/tb_hub75e_rx.sv
// Self-checking bench for hub75e_rx: randomized HUB75E lines against a
// line-level reference model, with a scoreboard fed by a write monitor.
module tb_hub75e_rx;

    localparam int COLS  = 64;
    localparam int ROW_W = 4;
    localparam int COL_W = 6;
    localparam int AW    = ROW_W + COL_W;
    localparam int EW    = AW + 8;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             hclk = 1'b0, lat = 1'b0;
    logic             r0 = 0, g0 = 0, b0 = 0, r1 = 0, g1 = 0, b1 = 0;
    logic [ROW_W-1:0] addr = '0;
    logic             ram_wr_en_o;
    logic [AW-1:0]    ram_wr_addr_o;
    logic [2:0]       ram_wr_data_ch0_o, ram_wr_data_ch1_o;
    logic             busy_o, frame_done_o, len_err_o, ovf_err_o;

    always #5 clk_i = ~clk_i;

    hub75e_rx #(.COLS(COLS), .ROW_W(ROW_W)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .hub75e_clk_i      (hclk),
        .hub75e_lat_i      (lat),
        .hub75e_r0_i       (r0),
        .hub75e_g0_i       (g0),
        .hub75e_b0_i       (b0),
        .hub75e_r1_i       (r1),
        .hub75e_g1_i       (g1),
        .hub75e_b1_i       (b1),
        .hub75e_addr_i     (addr),
        .ram_wr_en_o       (ram_wr_en_o),
        .ram_wr_addr_o     (ram_wr_addr_o),
        .ram_wr_data_ch0_o (ram_wr_data_ch0_o),
        .ram_wr_data_ch1_o (ram_wr_data_ch1_o),
        .busy_o            (busy_o),
        .frame_done_o      (frame_done_o),
        .len_err_o         (len_err_o),
        .ovf_err_o         (ovf_err_o)
    );

    // Scoreboard entry: {len_err seen the cycle before col 0, frame_done, addr, ch0, ch1}
    logic [EW-1:0] exp_q[$];
    logic [5:0]    pix_q[$];
    logic [5:0]    line_m[COLS];
    int checks = 0, errors = 0;
    int exp_len = 0, exp_ovf = 0, exp_frame = 0;
    int act_len = 0, act_ovf = 0, act_frame = 0;
    logic prev_len = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected write per observed write.
    always @(negedge clk_i) begin
        logic [EW-1:0] act, e;
        if (len_err_o)    act_len++;
        if (ovf_err_o)    act_ovf++;
        if (frame_done_o) act_frame++;
        if (busy_o || ram_wr_en_o) check("busy_vs_wr_en", {31'd0, busy_o}, {31'd0, ram_wr_en_o});
        if (ram_wr_en_o) begin
            act = {(ram_wr_addr_o[COL_W-1:0] == '0) ? prev_len : 1'b0, frame_done_o,
                   ram_wr_addr_o, ram_wr_data_ch0_o, ram_wr_data_ch1_o};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got 0x%0h expected no write", act);
            end else begin
                e = exp_q.pop_front();
                check("write", {14'd0, act}, {14'd0, e});
            end
        end
        prev_len = len_err_o;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Line-level model: pixels since the last accepted latch fill column COLS-1-k;
    // beyond COLS only the most recent COLS survive.
    task automatic accept_line(input logic [ROW_W-1:0] row);
        int n;
        bit bad;
        n = pix_q.size();
        if (n >= COLS) begin
            for (int c = 0; c < COLS; c++) line_m[c] = pix_q[n-1-c];
        end else begin
            for (int k = 0; k < n; k++) line_m[COLS-1-k] = pix_q[k];
        end
        bad = (n != COLS);
        if (bad) exp_len++;
        if (row == '1) exp_frame++;
        for (int c = 0; c < COLS; c++) begin
            exp_q.push_back({(c == 0) ? bad : 1'b0, (c == COLS-1) && (row == '1),
                             row, COL_W'(c), line_m[c]});
        end
        pix_q.delete();
    endtask

    task automatic shift_px(input logic [5:0] px);
        {r0, g0, b0, r1, g1, b1} = px;
        pix_q.push_back(px);
        cyc(2);
        hclk = 1'b1;
        cyc(3);
        hclk = 1'b0;
        cyc(1);
    endtask

    task automatic latch(input bit accept);
        if (accept) accept_line(addr);
        else exp_ovf++;
        lat = 1'b1;
        cyc(3);
        lat = 1'b0;
        cyc(3);
    endtask

    // Last pixel clock and latch rise together.
    task automatic shift_px_with_latch(input logic [5:0] px);
        {r0, g0, b0, r1, g1, b1} = px;
        pix_q.push_back(px);
        accept_line(addr);
        cyc(2);
        hclk = 1'b1;
        lat  = 1'b1;
        cyc(3);
        hclk = 1'b0;
        lat  = 1'b0;
        cyc(3);
    endtask

    task automatic rand_line(input logic [ROW_W-1:0] row, input int n);
        addr = row;
        for (int k = 0; k < n; k++) shift_px(6'($urandom_range(0, 63)));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) cyc(1);
        check(name, exp_q.size(), 0);
        cyc(2);
    endtask

    initial begin
        logic [2:0] k3;
        bit found;
        for (int c = 0; c < COLS; c++) line_m[c] = '0;

        cyc(3);
        check("reset_outputs",
              {14'd0, ram_wr_en_o, ram_wr_addr_o, ram_wr_data_ch0_o, ram_wr_data_ch1_o,
               busy_o, frame_done_o, len_err_o, ovf_err_o}, 32'd0);
        rst_i = 1'b0;
        cyc(3);

        // Single known line at row 5.
        addr = 4'd5;
        for (int k = 0; k < COLS; k++) begin
            k3 = 3'(k);
            shift_px({k3[0], k3[1], k3[2], ~k3[0], ~k3[1], ~k3[2]});
        end
        latch(1'b1);
        drain("single_line_drain");
        check("single_line_len_err", act_len, 0);

        // Full frame, rows 0..15.
        for (int r = 0; r < 16; r++) begin
            rand_line(ROW_W'(r), COLS);
            latch(1'b1);
        end
        drain("frame_drain");
        check("frame_done_count", act_frame, 1);
        check("frame_len_err", act_len, 0);

        // Short line (stale cols 0..3) and long line (last 64 kept).
        rand_line(4'd2, 60);
        latch(1'b1);
        drain("short_drain");
        check("short_len_err", act_len, 1);
        rand_line(4'd9, 70);
        latch(1'b1);
        drain("long_drain");
        check("long_len_err", act_len, 2);

        // Overrun: a latch during the flush is dropped and the count carries on.
        rand_line(4'd7, COLS);
        latch(1'b1);
        rand_line(4'd7, 2);
        latch(1'b0);
        rand_line(4'd8, COLS - 2);
        latch(1'b1);
        drain("overrun_drain");
        check("overrun_ovf_count", act_ovf, 1);
        check("overrun_len_err", act_len, 2);

        // Clock and latch edges in the same cycle on the last pixel.
        rand_line(4'd15, COLS - 1);
        shift_px_with_latch(6'($urandom_range(0, 63)));
        drain("same_cycle_drain");
        check("same_cycle_len_err", act_len, 2);
        check("same_cycle_frame_done", act_frame, 2);

        // Random-length lines.
        for (int i = 0; i < 3; i++) begin
            rand_line(ROW_W'($urandom_range(0, 15)), $urandom_range(62, 66));
            latch(1'b1);
            drain("random_drain");
        end

        // Reset in the middle of a flush.
        rand_line(4'd3, COLS);
        latch(1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk_i);
            #1;
            if (ram_wr_en_o && ram_wr_addr_o[COL_W-1:0] == 6'd20) found = 1'b1;
        end
        check("reset_col20_reached", {31'd0, found}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("reset_mid_flush_outputs",
              {14'd0, ram_wr_en_o, ram_wr_addr_o, ram_wr_data_ch0_o, ram_wr_data_ch1_o,
               busy_o, frame_done_o, len_err_o, ovf_err_o}, 32'd0);
        check("reset_pending_writes", exp_q.size(), COLS - 21);
        exp_q.delete();
        pix_q.delete();
        for (int c = 0; c < COLS; c++) line_m[c] = '0;
        cyc(2);
        rst_i = 1'b0;
        cyc(20);
        check("reset_no_writes", exp_q.size(), 0);

        // Fresh line after reset.
        rand_line(4'd11, COLS);
        latch(1'b1);
        drain("fresh_drain");

        check("total_len_err", act_len, exp_len);
        check("total_ovf", act_ovf, exp_ovf);
        check("total_frame_done", act_frame, exp_frame);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hub75e_rx.md
# hub75e_rx

HUB75E bus receiver: samples a HUB75E panel bus (the outputs of our waveform generator, looped back or probed), reassembles each shifted line, and writes it to a pixel RAM. Used for board-level loopback self-test and for capturing frames from external HUB75E sources. Sits between the FPGA input pins and a dual-port capture RAM.

## Interface
Parameters:
- COLS, 64, pixels shifted per line (power of two, ≥4)
- ROW_W, 4, width of the row address bus
- Derived: COL_W = $clog2(COLS); AW = ROW_W + COL_W

Ports:
- clk_i  in  1  system clock; sole clock of the block
- rst_i  in  1  reset; synchronous, active-high
- hub75e_clk_i  in  1  bus shift clock (asynchronous to clk_i)
- hub75e_lat_i  in  1  bus latch
- hub75e_r0_i, hub75e_g0_i, hub75e_b0_i  in  1 each  upper-half pixel bits
- hub75e_r1_i, hub75e_g1_i, hub75e_b1_i  in  1 each  lower-half pixel bits
- hub75e_addr_i  in  ROW_W  row address
- ram_wr_en_o  out  1  RAM write strobe
- ram_wr_addr_o  out  AW  {row, col}
- ram_wr_data_ch0_o  out  3  {r0,g0,b0}
- ram_wr_data_ch1_o  out  3  {r1,g1,b1}
- busy_o  out  1  line flush in progress
- frame_done_o  out  1  one-cycle pulse, last row of a frame written
- len_err_o  out  1  one-cycle pulse, line length ≠ COLS
- ovf_err_o  out  1  one-cycle pulse, latch dropped during flush

## Operation
- All bus inputs pass through the same 2-FF synchronizer, then a 1-FF delay for edge detection; data, addr and edges stay mutually aligned.
- Shift: on each detected hub75e_clk rising edge, shift the 6 data bits into a COLS×6 shift register; the k-th pixel after a latch ends in column COLS-1-k. Edge counter (COL_W+1 bits) increments, saturating at COLS+1.
- States (shared typedef): IDLE, FLUSH.
- IDLE + detected latch rising edge: snapshot shift register into holding buffer, capture row = synchronized addr, pulse len_err_o if edge count ≠ COLS, clear edge counter, go FLUSH.
- FLUSH: one write per cycle, col 0..COLS-1, data from holding buffer; after col COLS-1 go IDLE. Shifting continues unaffected during FLUSH.
- Latch rising edge detected in FLUSH: dropped, ovf_err_o pulses, edge counter not cleared, no len_err_o.
- frame_done_o pulses in the cycle of the write with col = COLS-1 and row = all ones.
- Clock edge and latch edge detected in the same cycle: the pixel is shifted first and included in the snapshot.
- More than COLS clocks: only the last COLS pixels kept; fewer: untouched columns keep stale contents; both flag len_err_o.

## Timing
- Reset (rst_i high at a clk_i edge): state IDLE, counters, synchronizers and shift/holding registers 0; every output 0. Reset mid-FLUSH aborts the flush with no further writes.
- Bus requirement: hub75e_clk high and low ≥2 clk_i cycles each; data/addr stable ≥1 clk_i before and after the hub75e_clk rising edge; latch high ≥2 clk_i cycles.
- Latch pin rise to detection: 3 clk_i cycles (cycle T). Writes on T+1..T+COLS; busy_o high T+1..T+COLS; len_err_o at T; frame_done_o at T+COLS.
- Next latch accepted from T+COLS+1.

## Structure
- hub75e_pkg: COLS/ROW_W defaults, rx state_t typedef {IDLE, FLUSH}.
- Sub-module hub75e_rx_sync: parameterised-width 2-FF synchronizer plus rising-edge detector, synchronous active-high reset; instantiated once for the 2+6+ROW_W bus bits.
- Shift register, holding buffer, counters and FSM live in hub75e_rx.

## Test plan
- Single line: 64 pixels, pixel k = {r0=k[0],g0=k[1],b0=k[2]}, ch1 inverted, addr=5, latch -> 64 writes at 0x140..0x17F; col c carries pixel 63-c; no error pulses.
- Full frame: rows 0..15 of 64 pixels -> 1024 writes, frame_done_o exactly once, coinciding with write to addr 0x3FF.
- Short line: 60 clocks then latch -> len_err_o one pulse at T; cols 4..63 new, cols 0..3 stale; 70 clocks -> len_err_o, last 64 pixels kept.
- Overrun: second latch 10 cycles after first detection -> ovf_err_o one pulse; only 64 writes total; next latch after T+65 accepted.
- Same-cycle clock and latch edge on the 64th pixel -> pixel included, no len_err_o.
- rst_i asserted at write col 20 -> ram_wr_en_o low next cycle, all outputs 0, fresh line captures normally.
